decode_iq: RTL and testbench

Parametrised successor to the single-register decode stage. It adds an instruction queue of IQ_DEPTH entries between fetch and execute, with valid/ready handshakes on both sides in place of global stall inputs. The block decodes the head entry into register numbers and immediate forms, and computes absolute branch and jump targets. i_drop flushes the queue on a redirect.

---
 rtl/decode_iq.sv | 170 +++++++++++++++++
 tb/tb_decode_iq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_iq.sv
// decode_iq: instruction queue between fetch and execute, with decode of the
// head entry.
// Fetch pushes {instr, pc} through a valid/ready handshake, and execute pops
// the head the same way. The head entry is decoded combinationally into
// register numbers, immediate forms and absolute branch/jump targets.
// An empty queue presents all-zero outputs, which is the NOP encoding.
module decode_iq #(
    parameter int IQ_DEPTH = 4,
    parameter int ADDR_W   = 32,
    parameter int PC_HI_W  = 4
) (
    input  logic                        clk,
    input  logic                        nrst,
    input  logic                        i_drop,
    input  logic                        i_vld,
    input  logic [31:0]                 i_instr,
    input  logic [ADDR_W-1:0]           i_pc,
    output logic                        o_rdy,
    output logic                        o_vld,
    input  logic                        i_rdy,
    output logic [ADDR_W-1:0]           o_pc,
    output logic [5:0]                  o_op,
    output logic [4:0]                  o_dst_gpr,
    output logic [4:0]                  o_src1_gpr,
    output logic [4:0]                  o_src2_gpr,
    output logic [4:0]                  o_shamt,
    output logic [5:0]                  o_func,
    output logic [31:0]                 o_src3_se_v,
    output logic [31:0]                 o_src3_ze_v,
    output logic [31:0]                 o_src3_sh16_v,
    output logic [ADDR_W-1:0]           o_src3_j_v,
    output logic [ADDR_W-1:0]           o_br_tgt,
    output logic [$clog2(IQ_DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(IQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // Width of the jump-index field that sits between the kept PC bits and
    // the two zero alignment bits.
    localparam int JLO_W = ADDR_W - PC_HI_W - 2;

    typedef struct packed {
        logic [31:0]       instr;
        logic [ADDR_W-1:0] pc;
    } iq_entry_t;

    iq_entry_t          mem [IQ_DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;

    logic               push;
    logic               pop;

    iq_entry_t          head;
    logic [31:0]        head_instr;
    logic [ADDR_W-1:0]  head_pc;
    logic [15:0]        imm;
    logic [ADDR_W-1:0]  pc4;
    logic [31:0]        jfield;
    logic [JLO_W-1:0]   j_lo;
    logic [ADDR_W-1:0]  br_off;
    logic [ADDR_W-1:0]  j_raw;
    logic [ADDR_W-1:0]  br_raw;

    // Handshake flags depend on the registered count only, so there is no
    // combinational path from i_vld or i_rdy to any output.
    assign o_rdy   = (count != CNT_W'(IQ_DEPTH));
    assign o_vld   = (count != '0);
    assign o_count = count;

    assign push = i_vld & o_rdy;
    assign pop  = o_vld & i_rdy;

    // Pointer and occupancy state. A drop empties the queue and overrides any
    // push or pop in the same cycle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (i_drop) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage has no reset. Its contents matter only while the
    // occupancy count says they are live.
    always_ff @(posedge clk) begin
        if (push && !i_drop)
            mem[wr_ptr] <= '{instr: i_instr, pc: i_pc};
    end

    // Head selection. Stale storage is masked while the queue is empty.
    always_comb begin
        head       = mem[rd_ptr];
        head_instr = '0;
        head_pc    = '0;
        if (o_vld) begin
            head_instr = head.instr;
            head_pc    = head.pc;
        end
    end

    // Fixed-position fields and immediate forms.
    always_comb begin
        o_pc          = head_pc;
        o_op          = head_instr[31:26];
        o_src1_gpr    = head_instr[25:21];
        o_src2_gpr    = head_instr[20:16];
        o_dst_gpr     = head_instr[15:11];
        o_shamt       = head_instr[10:6];
        o_func        = head_instr[5:0];
        imm           = head_instr[15:0];
        o_src3_se_v   = {{16{imm[15]}}, imm};
        o_src3_ze_v   = {16'h0000, imm};
        o_src3_sh16_v = {imm, 16'h0000};
    end

    // Jump index. instr[25:0] is zero-extended or truncated to JLO_W bits.
    // A bit loop keeps this legal for every ADDR_W/PC_HI_W combination.
    always_comb begin
        jfield = {6'b000000, head_instr[25:0]};
        j_lo   = '0;
        for (int i = 0; i < JLO_W; i++) begin
            if (i < 26)
                j_lo[i] = jfield[i[4:0]];
        end
    end

    // Branch offset is sign-extended {imm, 2'b00}, built in ADDR_W bits.
    // This stays valid even when ADDR_W is narrower than 18 bits.
    always_comb begin
        logic [4:0] k;
        k      = '0;
        br_off = '0;
        for (int i = 2; i < ADDR_W; i++) begin
            if (i < 18) begin
                k         = 5'(i - 2);
                br_off[i] = imm[k[3:0]];
            end else begin
                br_off[i] = imm[15];
            end
        end
    end

    // Targets are relative to pc4, and carries past ADDR_W are discarded.
    // Both targets are forced to zero when the queue is empty, so the
    // empty-queue outputs read as a NOP.
    always_comb begin
        pc4        = head_pc + ADDR_W'(4);
        j_raw      = {pc4[ADDR_W-1 -: PC_HI_W], j_lo, 2'b00};
        br_raw     = pc4 + br_off;
        o_src3_j_v = o_vld ? j_raw  : '0;
        o_br_tgt   = o_vld ? br_raw : '0;
    end

endmodule

// File: tb/tb_decode_iq.sv
// Directed bench for decode_iq.
// A vector table covers the head decode. Hand-written sequences cover full,
// wrap, drop and asynchronous-reset behaviour.
module tb_decode_iq;

    logic        clk;
    logic        nrst;
    logic        i_drop;
    logic        i_vld;
    logic [31:0] i_instr;
    logic [31:0] i_pc;
    logic        o_rdy;
    logic        o_vld;
    logic        i_rdy;
    logic [31:0] o_pc;
    logic [5:0]  o_op;
    logic [4:0]  o_dst_gpr;
    logic [4:0]  o_src1_gpr;
    logic [4:0]  o_src2_gpr;
    logic [4:0]  o_shamt;
    logic [5:0]  o_func;
    logic [31:0] o_src3_se_v;
    logic [31:0] o_src3_ze_v;
    logic [31:0] o_src3_sh16_v;
    logic [31:0] o_src3_j_v;
    logic [31:0] o_br_tgt;
    logic [2:0]  o_count;

    int checks = 0;
    int errors = 0;

    decode_iq #(.IQ_DEPTH(4), .ADDR_W(32), .PC_HI_W(4)) dut (
        .clk(clk), .nrst(nrst), .i_drop(i_drop), .i_vld(i_vld),
        .i_instr(i_instr), .i_pc(i_pc), .o_rdy(o_rdy), .o_vld(o_vld),
        .i_rdy(i_rdy), .o_pc(o_pc), .o_op(o_op), .o_dst_gpr(o_dst_gpr),
        .o_src1_gpr(o_src1_gpr), .o_src2_gpr(o_src2_gpr), .o_shamt(o_shamt),
        .o_func(o_func), .o_src3_se_v(o_src3_se_v), .o_src3_ze_v(o_src3_ze_v),
        .o_src3_sh16_v(o_src3_sh16_v), .o_src3_j_v(o_src3_j_v),
        .o_br_tgt(o_br_tgt), .o_count(o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [5:0]  op;
        logic [4:0]  dst;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic [4:0]  sh;
        logic [5:0]  fn;
        logic [31:0] se;
        logic [31:0] ze;
        logic [31:0] h16;
        logic [31:0] jv;
        logic [31:0] br;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock. Outputs are then sampled and inputs changed 1 ns
    // after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [31:0] ins, input logic [31:0] pc);
        i_vld = 1'b1; i_instr = ins; i_pc = pc;
        step();
        i_vld = 1'b0;
    endtask

    task automatic drain();
        i_rdy = 1'b1;
        for (int n = 0; n < 8; n++) if (o_vld) step();
        i_rdy = 1'b0;
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, " o_vld"},   64'(o_vld),   64'd0);
        chk({tag, " o_count"}, 64'(o_count), 64'd0);
        chk({tag, " o_rdy"},   64'(o_rdy),   64'd1);
        chk({tag, " o_pc"},    64'(o_pc),    64'd0);
        chk({tag, " o_br"},    64'(o_br_tgt),64'd0);
        chk({tag, " o_op"},    64'(o_op),    64'd0);
    endtask

    initial begin
        vecs[0] = '{32'h3C011234, 32'h00400000, 6'h0F, 5'd2,  5'd0,  5'd1, 5'd8,  6'h34,
                    32'h00001234, 32'h00001234, 32'h12340000, 32'h000448D0, 32'h004048D4};
        vecs[1] = '{32'h1000FFFF, 32'h00400010, 6'h04, 5'd31, 5'd0,  5'd0, 5'd31, 6'h3F,
                    32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFF0000, 32'h0003FFFC, 32'h00400010};
        vecs[2] = '{32'h08000010, 32'hA0000000, 6'h02, 5'd0,  5'd0,  5'd0, 5'd0,  6'h10,
                    32'h00000010, 32'h00000010, 32'h00100000, 32'hA0000040, 32'hA0000044};
        vecs[3] = '{32'h24228000, 32'h00001000, 6'h09, 5'd16, 5'd1,  5'd2, 5'd0,  6'h00,
                    32'hFFFF8000, 32'h00008000, 32'h80000000, 32'h008A0000, 32'hFFFE1004};
        vecs[4] = '{32'h03E0F8C9, 32'hFFFFFFFC, 6'h00, 5'd31, 5'd31, 5'd0, 5'd3,  6'h09,
                    32'hFFFFF8C9, 32'h0000F8C9, 32'hF8C90000, 32'h0F83E324, 32'hFFFFE324};

        nrst = 1'b0; i_drop = 1'b0; i_vld = 1'b0; i_rdy = 1'b0;
        i_instr = '0; i_pc = '0;
        #12;
        chk_empty("reset");
        nrst = 1'b1;
        step();

        // Head decode: push one entry, check the fields, pop it, then check
        // that the outputs return to zero.
        for (int v = 0; v < 5; v++) begin
            push1(vecs[v].instr, vecs[v].pc);
            chk($sformatf("v%0d vld", v),  64'(o_vld),         64'd1);
            chk($sformatf("v%0d cnt", v),  64'(o_count),       64'd1);
            chk($sformatf("v%0d pc", v),   64'(o_pc),          64'(vecs[v].pc));
            chk($sformatf("v%0d op", v),   64'(o_op),          64'(vecs[v].op));
            chk($sformatf("v%0d dst", v),  64'(o_dst_gpr),     64'(vecs[v].dst));
            chk($sformatf("v%0d s1", v),   64'(o_src1_gpr),    64'(vecs[v].s1));
            chk($sformatf("v%0d s2", v),   64'(o_src2_gpr),    64'(vecs[v].s2));
            chk($sformatf("v%0d sh", v),   64'(o_shamt),       64'(vecs[v].sh));
            chk($sformatf("v%0d fn", v),   64'(o_func),        64'(vecs[v].fn));
            chk($sformatf("v%0d se", v),   64'(o_src3_se_v),   64'(vecs[v].se));
            chk($sformatf("v%0d ze", v),   64'(o_src3_ze_v),   64'(vecs[v].ze));
            chk($sformatf("v%0d h16", v),  64'(o_src3_sh16_v), 64'(vecs[v].h16));
            chk($sformatf("v%0d jv", v),   64'(o_src3_j_v),    64'(vecs[v].jv));
            chk($sformatf("v%0d br", v),   64'(o_br_tgt),      64'(vecs[v].br));
            i_rdy = 1'b1;
            step();
            i_rdy = 1'b0;
            chk_empty($sformatf("v%0d pop", v));
            chk($sformatf("v%0d pop jv", v), 64'(o_src3_j_v), 64'd0);
            chk($sformatf("v%0d pop s2", v), 64'(o_src2_gpr), 64'd0);
        end

        // Fill to capacity. A fifth push is refused, and the pops come out in
        // FIFO order.
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("fill rdy%0d", k), 64'(o_rdy), 64'd1);
            push1(32'h00000000 + k, 32'h100 + 4 * k);
        end
        chk("full cnt", 64'(o_count), 64'd4);
        chk("full rdy", 64'(o_rdy),   64'd0);
        push1(32'hDEADBEEF, 32'h200);
        chk("full refuse cnt", 64'(o_count), 64'd4);
        chk("full head pc",    64'(o_pc),    64'h100);
        i_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain pc%0d", k), 64'(o_pc), 64'(32'h100 + 4 * k));
            step();
        end
        i_rdy = 1'b0;
        chk_empty("drained");

        // Steady push and pop at occupancy 1, long enough to wrap the
        // pointers several times.
        push1(32'h00000020, 32'h1000);
        i_vld = 1'b1; i_rdy = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            i_pc = 32'h1000 + 4 * k;
            step();
            chk($sformatf("wrap cnt%0d", k), 64'(o_count), 64'd1);
            chk($sformatf("wrap pc%0d", k),  64'(o_pc),    64'(32'h1000 + 4 * k));
        end
        i_vld = 1'b0;
        drain();
        chk_empty("wrap end");

        // A drop at count 3, with a push and a pop in the same cycle, leaves
        // nothing in the queue.
        push1(32'h11111111, 32'h300);
        push1(32'h22222222, 32'h304);
        push1(32'h33333333, 32'h308);
        chk("pre-drop cnt", 64'(o_count), 64'd3);
        i_vld = 1'b1; i_instr = 32'h44444444; i_pc = 32'h30C; i_rdy = 1'b1; i_drop = 1'b1;
        step();
        i_vld = 1'b0; i_rdy = 1'b0; i_drop = 1'b0;
        chk_empty("drop");
        push1(32'h3C011234, 32'h400);
        chk("post-drop pc",  64'(o_pc),    64'h400);
        chk("post-drop cnt", 64'(o_count), 64'd1);
        chk("post-drop op",  64'(o_op),    64'h0F);
        drain();
        i_drop = 1'b1;
        step();
        i_drop = 1'b0;
        chk_empty("drop empty");

        // Asserting reset in the middle of a cycle empties the queue at once.
        push1(32'h55555555, 32'h500);
        push1(32'h66666666, 32'h504);
        chk("pre-rst cnt", 64'(o_count), 64'd2);
        #2 nrst = 1'b0;
        #1 chk_empty("async rst");
        #2 nrst = 1'b1;
        push1(32'h08000010, 32'hA0000000);
        chk("post-rst pc",  64'(o_pc),       64'hA0000000);
        chk("post-rst cnt", 64'(o_count),    64'd1);
        chk("post-rst jv",  64'(o_src3_j_v), 64'hA0000040);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
